axi4_lite_master_ctrl: RTL
==========================

Name:
axi4_lite_master_ctrl

Overview:
- Command-driven AXI4-Lite master that sequences single read and write transactions into the team's 32-register AXI4-Lite slave (5-bit address, 32-bit data).
- Accepts one command at a time from a simple valid/ready command port and drives the five AXI channels.
- Returns a one-cycle response pulse with read data and response code.
- Per-transaction watchdog aborts hung transactions so upstream sequencers never deadlock.

Parameters:
ADDRESS, 5, AXI and command address width
DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
TIMEOUT_CYCLES, 64, max cycles a transaction may stay outstanding before abort (>=2)

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETN  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller idle, command accepted when cmd_valid&&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDRESS  target register address
cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_WIDTH  read data (0 for writes and aborts)
rsp_resp  out  2  BRESP/RRESP from slave; 2'b11 = watchdog abort
M_AWADDR  out  ADDRESS  write address
M_AWVALID  out  1  write address valid
M_AWREADY  in  1  write address ready
M_WDATA  out  DATA_WIDTH  write data
M_WSTRB  out  DATA_WIDTH/8  write strobe, all ones while M_WVALID, else 0
M_WVALID  out  1  write data valid
M_WREADY  in  1  write data ready
M_BRESP  in  2  write response
M_BVALID  in  1  write response valid
M_BREADY  out  1  write response ready
M_ARADDR  out  ADDRESS  read address
M_ARVALID  out  1  read address valid
M_ARREADY  in  1  read address ready
M_RDATA  in  DATA_WIDTH  read data
M_RRESP  in  2  read response
M_RVALID  in  1  read data valid
M_RREADY  out  1  read data ready

Behaviour:
- Reset (async assert, sync release): state=IDLE. All AXI valids/readies, addresses, data and strobe = 0. rsp_valid=0, rsp_rdata=0, rsp_resp=0, watchdog=0.
- cmd_ready = (state==IDLE); combinational from state only, never from cmd_valid.
- All AXI outputs and rsp_* are registered.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE.
- IDLE:
  - Write command accepted: latch addr/data, M_AWVALID=M_WVALID=1 next cycle, go WR_REQ.
  - Read command accepted: M_ARVALID=1 next cycle, go RD_REQ.
- WR_REQ:
  - AW and W handshakes tracked independently (aw_done, w_done flags). Each valid drops the cycle after its own handshake; either order or same cycle is legal.
  - Valids are never withdrawn before handshake except on abort.
  - When both are done, go WR_RESP with M_BREADY=1.
- WR_RESP: on M_BVALID&&M_BREADY capture M_BRESP, M_BREADY=0, go DONE.
- RD_REQ: on M_ARVALID&&M_ARREADY, M_ARVALID=0, M_RREADY=1, go RD_DATA.
- RD_DATA: on M_RVALID&&M_RREADY capture M_RDATA/M_RRESP, M_RREADY=0, go DONE.
- DONE: rsp_valid=1 for exactly one cycle with captured rsp_rdata/rsp_resp, then IDLE. Next command can be accepted the cycle after the rsp_valid pulse.
- Watchdog:
  - Clears on command acceptance and increments each cycle in WR_REQ/WR_RESP/RD_REQ/RD_DATA.
  - On reaching TIMEOUT_CYCLES: all AXI valids/readies forced 0, go DONE with rsp_resp=2'b11, rsp_rdata=0.
  - Abort is an intentional recovery deviation from AXI; the slave must be reset afterwards.
- Handshake and timeout in the same cycle: the handshake wins and the transaction completes normally.
- Reset mid-transaction: immediate return to IDLE with outputs at reset values; no rsp_valid is generated for the lost command.

Test Plan:
- After reset, read addr 5 -> exactly one rsp_valid pulse, rsp_rdata=32'h5, rsp_resp=2'b00; no AW/W activity.
- Write addr 3 data 32'hDEADBEEF, then read addr 3 -> write rsp_resp=00, then read rsp_rdata=32'hDEADBEEF; M_WSTRB=4'hF during W.
- Stub slave: AWREADY 3 cycles before WREADY, then reversed order, then same cycle -> each valid drops the cycle after its own handshake; single B, rsp_resp=00 in all cases.
- Stub slave never asserts M_ARREADY, TIMEOUT_CYCLES=16 -> rsp_valid 16 cycles after M_ARVALID rises, rsp_resp=2'b11, M_ARVALID=0 afterwards, cmd_ready=1 next cycle.
- cmd_valid held high over 4 alternating write/read commands to addrs 0..3 -> each accepted only in IDLE, one rsp_valid per command, read data matches prior writes.
- ARESETN pulsed low mid-WR_RESP -> outputs 0 in the same cycle without waiting for ACLK, no rsp_valid, next read of addr 7 returns 32'h7.

Source files
------------

// File: rtl/axi4_lite_master_ctrl.sv
// Command-driven AXI4-Lite master: runs one single-beat read or write at a time
// against a 32-register slave and reports completion, with a per-transaction watchdog.
module axi4_lite_master_ctrl #(
    parameter int ADDRESS        = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDRESS-1:0]        cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic [ADDRESS-1:0]        M_AWADDR,
    output logic                      M_AWVALID,
    input  logic                      M_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_WSTRB,
    output logic                      M_WVALID,
    input  logic                      M_WREADY,
    input  logic [1:0]                M_BRESP,
    input  logic                      M_BVALID,
    output logic                      M_BREADY,
    output logic [ADDRESS-1:0]        M_ARADDR,
    output logic                      M_ARVALID,
    input  logic                      M_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_RDATA,
    input  logic [1:0]                M_RRESP,
    input  logic                      M_RVALID,
    output logic                      M_RREADY
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WDOG_W-1:0] WDOG_ONE  = WDOG_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_DONE
    } state_t;

    state_t                  r_state, w_stateNext;
    logic                    r_awvalid, w_awvalid;
    logic                    r_wvalid, w_wvalid;
    logic                    r_bready, w_bready;
    logic                    r_arvalid, w_arvalid;
    logic                    r_rready, w_rready;
    logic [ADDRESS-1:0]      r_awaddr, w_awaddr;
    logic [ADDRESS-1:0]      r_araddr, w_araddr;
    logic [DATA_WIDTH-1:0]   r_wdata, w_wdata;
    logic [STRB_W-1:0]       r_wstrb, w_wstrb;
    logic                    r_awDone, w_awDone;
    logic                    r_wDone, w_wDone;
    logic [WDOG_W-1:0]       r_wdog, w_wdog;
    logic                    r_rspValid, w_rspValid;
    logic [DATA_WIDTH-1:0]   r_rspRdata, w_rspRdata;
    logic [1:0]              r_rspResp, w_rspResp;

    logic w_awHs, w_wHs, w_bHs, w_arHs, w_rHs;
    logic w_timeout, w_abort;

    assign w_awHs    = r_awvalid && M_AWREADY;
    assign w_wHs     = r_wvalid  && M_WREADY;
    assign w_bHs     = r_bready  && M_BVALID;
    assign w_arHs    = r_arvalid && M_ARREADY;
    assign w_rHs     = r_rready  && M_RVALID;
    assign w_timeout = (r_wdog == WDOG_LAST);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state    <= ST_IDLE;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
            r_awaddr   <= '0;
            r_araddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_awDone   <= 1'b0;
            r_wDone    <= 1'b0;
            r_wdog     <= '0;
            r_rspValid <= 1'b0;
            r_rspRdata <= '0;
            r_rspResp  <= 2'b00;
        end else begin
            r_state    <= w_stateNext;
            r_awvalid  <= w_awvalid;
            r_wvalid   <= w_wvalid;
            r_bready   <= w_bready;
            r_arvalid  <= w_arvalid;
            r_rready   <= w_rready;
            r_awaddr   <= w_awaddr;
            r_araddr   <= w_araddr;
            r_wdata    <= w_wdata;
            r_wstrb    <= w_wstrb;
            r_awDone   <= w_awDone;
            r_wDone    <= w_wDone;
            r_wdog     <= w_wdog;
            r_rspValid <= w_rspValid;
            r_rspRdata <= w_rspRdata;
            r_rspResp  <= w_rspResp;
        end
    end

    // A completing handshake is checked before the watchdog, so it wins a tie.
    always_comb begin
        w_stateNext = r_state;
        w_awvalid   = r_awvalid;
        w_wvalid    = r_wvalid;
        w_bready    = r_bready;
        w_arvalid   = r_arvalid;
        w_rready    = r_rready;
        w_awaddr    = r_awaddr;
        w_araddr    = r_araddr;
        w_wdata     = r_wdata;
        w_wstrb     = r_wstrb;
        w_awDone    = r_awDone;
        w_wDone     = r_wDone;
        w_wdog      = r_wdog;
        w_rspValid  = 1'b0;
        w_rspRdata  = r_rspRdata;
        w_rspResp   = r_rspResp;
        w_abort     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_wdog   = '0;
                    w_awDone = 1'b0;
                    w_wDone  = 1'b0;
                    if (cmd_write) begin
                        w_awaddr    = cmd_addr;
                        w_wdata     = cmd_wdata;
                        w_wstrb     = '1;
                        w_awvalid   = 1'b1;
                        w_wvalid    = 1'b1;
                        w_stateNext = ST_WR_REQ;
                    end else begin
                        w_araddr    = cmd_addr;
                        w_arvalid   = 1'b1;
                        w_stateNext = ST_RD_REQ;
                    end
                end
            end
            ST_WR_REQ: begin
                w_wdog = r_wdog + WDOG_ONE;
                if (w_awHs) begin
                    w_awvalid = 1'b0;
                    w_awDone  = 1'b1;
                end
                if (w_wHs) begin
                    w_wvalid = 1'b0;
                    w_wstrb  = '0;
                    w_wDone  = 1'b1;
                end
                if ((r_awDone || w_awHs) && (r_wDone || w_wHs)) begin
                    w_bready    = 1'b1;
                    w_stateNext = ST_WR_RESP;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                end
            end
            ST_WR_RESP: begin
                w_wdog = r_wdog + WDOG_ONE;
                if (w_bHs) begin
                    w_bready    = 1'b0;
                    w_rspValid  = 1'b1;
                    w_rspRdata  = '0;
                    w_rspResp   = M_BRESP;
                    w_stateNext = ST_DONE;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                end
            end
            ST_RD_REQ: begin
                w_wdog = r_wdog + WDOG_ONE;
                if (w_arHs) begin
                    w_arvalid   = 1'b0;
                    w_rready    = 1'b1;
                    w_stateNext = ST_RD_DATA;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                end
            end
            ST_RD_DATA: begin
                w_wdog = r_wdog + WDOG_ONE;
                if (w_rHs) begin
                    w_rready    = 1'b0;
                    w_rspValid  = 1'b1;
                    w_rspRdata  = M_RDATA;
                    w_rspResp   = M_RRESP;
                    w_stateNext = ST_DONE;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                end
            end
            ST_DONE: begin
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase

        // Abort drops every AXI request line; the slave needs a reset afterwards.
        if (w_abort) begin
            w_awvalid   = 1'b0;
            w_wvalid    = 1'b0;
            w_wstrb     = '0;
            w_bready    = 1'b0;
            w_arvalid   = 1'b0;
            w_rready    = 1'b0;
            w_rspValid  = 1'b1;
            w_rspRdata  = '0;
            w_rspResp   = 2'b11;
            w_stateNext = ST_DONE;
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign rsp_valid = r_rspValid;
    assign rsp_rdata = r_rspRdata;
    assign rsp_resp  = r_rspResp;
    assign M_AWADDR  = r_awaddr;
    assign M_AWVALID = r_awvalid;
    assign M_WDATA   = r_wdata;
    assign M_WSTRB   = r_wstrb;
    assign M_WVALID  = r_wvalid;
    assign M_BREADY  = r_bready;
    assign M_ARADDR  = r_araddr;
    assign M_ARVALID = r_arvalid;
    assign M_RREADY  = r_rready;

endmodule
